window_line_buffer: RTL and testbench

- Parametrised KxK sliding-window generator for the Sobel datapath; successor to the single-line shift buffer.
- Accepts a raster-order pixel stream with valid/ready handshake and stores KERNEL-1 full image lines in circular, column-addressed line memories.
- Emits one complete KxK window per accepted pixel once enough rows and columns are available.
- Tracks column/row position, marks the last window of each frame, and supports backpressure and a synchronous flush.

---
 rtl/window_line_buffer.sv | 121 ++++++++++++
 tb/tb_window_line_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_line_buffer.sv
// KxK sliding-window generator: KERNEL-1 column-addressed line memories feed a
// shift-in window register, with a single registered output stage.
module window_line_buffer #(
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100,
  parameter int DATA_WIDTH = 24,
  parameter int KERNEL     = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  output logic                                  win_valid,
  input  logic                                  out_ready,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]   win_data,
  output logic                                  win_last,
  output logic [$clog2(IMG_WIDTH)-1:0]          col_idx,
  output logic [$clog2(IMG_HEIGHT)-1:0]         row_idx
);

  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int WW    = KERNEL*KERNEL*DATA_WIDTH;
  localparam int LINES = KERNEL-1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT-1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL-1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL-1);

  logic [DATA_WIDTH-1:0] line_mem [LINES][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] col_vec  [KERNEL];
  logic [WW-1:0]         win_q;
  logic [WW-1:0]         win_next;
  logic                  accept;
  logic                  produce;
  logic                  at_last;

  assign in_ready = !clear && (out_ready || !win_valid);
  assign accept   = in_valid && in_ready;
  assign produce  = (row_idx >= ROW_FIRST) && (col_idx >= COL_FIRST);
  assign at_last  = (row_idx == ROW_LAST) && (col_idx == COL_LAST);

  // line_mem[LINES-1] holds the oldest row, so it lands at the top of the column
  always_comb begin
    for (int r = 0; r < LINES; r++) begin
      col_vec[r] = line_mem[LINES-1-r][col_idx];
    end
    col_vec[KERNEL-1] = data_in;
  end

  always_comb begin
    win_next = win_q;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        if (c == KERNEL-1) begin
          win_next[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = col_vec[r];
        end else begin
          win_next[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] =
            win_q[(r*KERNEL+c+1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // One read and one write per line per accept keeps these as plain RAMs
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][col_idx] <= data_in;
      for (int k = 1; k < LINES; k++) begin
        line_mem[k][col_idx] <= line_mem[k-1][col_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (clear) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (accept) begin
      if (col_idx == COL_LAST) begin
        col_idx <= '0;
        row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
      end else begin
        col_idx <= col_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= win_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
    end else if (clear) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept && produce) begin
      win_valid <= 1'b1;
      win_data  <= win_next;
      win_last  <= at_last;
    end else if (out_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer: a 3x3/5x4 instance exercised with
// stalls, clear and reset, plus a 5x5/7x6 instance for layout and count.
module tb_window_line_buffer;

  localparam int AK = 3, AW = 5, AH = 4;
  localparam int BK = 5, BW = 7, BH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_a, a_clear, a_in_valid, a_in_ready, a_win_valid, a_out_ready, a_win_last;
  logic [7:0]   a_data_in;
  logic [71:0]  a_win_data;
  logic [2:0]   a_col;
  logic [1:0]   a_row;

  logic         rst_n_b, b_clear, b_in_valid, b_in_ready, b_win_valid, b_out_ready, b_win_last;
  logic [7:0]   b_data_in;
  logic [199:0] b_win_data;
  logic [2:0]   b_col;
  logic [2:0]   b_row;

  window_line_buffer #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .DATA_WIDTH(8), .KERNEL(AK)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .win_valid(a_win_valid), .out_ready(a_out_ready), .win_data(a_win_data),
    .win_last(a_win_last), .col_idx(a_col), .row_idx(a_row));

  window_line_buffer #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_WIDTH(8), .KERNEL(BK)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .win_valid(b_win_valid), .out_ready(b_out_ready), .win_data(b_win_data),
    .win_last(b_win_last), .col_idx(b_col), .row_idx(b_row));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference window: the KxK block of the frame image ending at (r,c)
  function automatic logic [199:0] model_win(input int k, input int r, input int c,
                                             input logic [7:0] im [8][8]);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        w[(i*k+j)*8 +: 8] = im[r-k+1+i][c-k+1+j];
    return w;
  endfunction

  // ---------------- scoreboard / monitor for instance A ----------------
  logic [7:0]   img_a [8][8];
  logic [200:0] qa [$];
  logic [200:0] ea;
  logic [72:0]  a_prev;
  int           pa_r = 0, pa_c = 0, a_wins = 0, a_lasts = 0;
  bit           a_pend = 0, a_stall = 0, rnd_ready = 0;

  always @(negedge clk) begin
    if (!rst_n_a) begin
      qa.delete(); pa_r = 0; pa_c = 0; a_pend = 0; a_stall = 0;
    end else begin
      if (a_pend) chk("a_latency", 256'(a_win_valid), 256'(1));
      a_pend = 0;
      if (a_stall) chk("a_hold", 256'({a_win_last, a_win_data}), 256'(a_prev));
      chk("a_in_ready", 256'(a_in_ready), 256'(!a_clear && (a_out_ready || !a_win_valid)));
      if (a_win_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_win: got window %0h expected none", a_win_data);
        end else begin
          ea = qa.pop_front();
          chk("a_win", 256'({a_win_last, a_win_data}), 256'({ea[200], ea[71:0]}));
        end
        a_wins++;
        if (a_win_last) a_lasts++;
      end
      a_stall = a_win_valid && !a_out_ready;
      a_prev  = {a_win_last, a_win_data};
      if (a_clear) begin
        qa.delete(); pa_r = 0; pa_c = 0; a_stall = 0;
      end else if (a_in_valid && a_in_ready) begin
        chk("a_pos", 256'({a_row, a_col}), 256'({pa_r[1:0], pa_c[2:0]}));
        img_a[pa_r][pa_c] = a_data_in;
        if (pa_r >= AK-1 && pa_c >= AK-1) begin
          qa.push_back({(pa_r == AH-1 && pa_c == AW-1), model_win(AK, pa_r, pa_c, img_a)});
          a_pend = 1;
        end
        pa_c++;
        if (pa_c == AW) begin
          pa_c = 0; pa_r++;
          if (pa_r == AH) pa_r = 0;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor for instance B ----------------
  logic [7:0]   img_b [8][8];
  logic [200:0] qb [$];
  logic [200:0] eb;
  int           pb_r = 0, pb_c = 0, b_wins = 0, b_lasts = 0;

  always @(negedge clk) begin
    if (!rst_n_b) begin
      qb.delete(); pb_r = 0; pb_c = 0;
    end else begin
      if (b_win_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_win: got window %0h expected none", b_win_data);
        end else begin
          eb = qb.pop_front();
          chk("b_win", 256'({b_win_last, b_win_data}), 256'(eb));
        end
        b_wins++;
        if (b_win_last) b_lasts++;
      end
      if (b_in_valid && b_in_ready) begin
        chk("b_pos", 256'({b_row, b_col}), 256'({pb_r[2:0], pb_c[2:0]}));
        img_b[pb_r][pb_c] = b_data_in;
        if (pb_r >= BK-1 && pb_c >= BK-1)
          qb.push_back({(pb_r == BH-1 && pb_c == BW-1), model_win(BK, pb_r, pb_c, img_b)});
        pb_c++;
        if (pb_c == BW) begin
          pb_c = 0; pb_r++;
          if (pb_r == BH) pb_r = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) a_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Sends raster pixels first..first+n-1 of a frame, value base + r*16 + c
  task automatic send_a(input int base, input int first, input int n, input bit rnd);
    for (int i = first; i < first + n; i++) begin
      int g;
      bit done;
      g = 0; done = 0;
      a_data_in = 8'(base + (i / AW) * 16 + (i % AW));
      while (!done) begin
        a_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        done = a_in_valid && a_in_ready;
        @(posedge clk); #1;
        g++;
        if (!done && g > 500) begin
          checks++; errors++;
          $display("FAIL a_send_timeout: pixel %0d not accepted within %0d cycles", i, g);
          done = 1;
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int g;
    g = 0;
    while ((qa.size() != 0 || a_win_valid) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 300) begin
      checks++; errors++;
      $display("FAIL a_drain: %0d windows still pending, expected 0", qa.size());
    end
  endtask

  task automatic count_a(input string name, input int wins, input int lasts);
    chk({name, "_wins"}, 256'(a_wins), 256'(wins));
    chk({name, "_lasts"}, 256'(a_lasts), 256'(lasts));
    a_wins = 0; a_lasts = 0;
  endtask

  initial begin
    rst_n_a = 0; rst_n_b = 0;
    a_clear = 0; a_in_valid = 0; a_out_ready = 1; a_data_in = '0;
    b_clear = 0; b_in_valid = 0; b_out_ready = 1; b_data_in = '0;
    #22;
    rst_n_a = 1; rst_n_b = 1;
    #1;
    chk("rst_outputs", 256'({a_win_valid, a_win_last, a_col, a_row, a_win_data}), 256'(0));
    @(posedge clk); #1;

    // basic frame
    a_wins = 0; a_lasts = 0;
    send_a(0, 0, AW*AH, 0);
    drain_a();
    count_a("basic", 6, 1);

    // backpressure for 5 cycles while a window is held
    fork
      send_a(0, 0, AW*AH, 0);
      begin
        int g;
        g = 0;
        while (!a_win_valid && g < 100) begin @(posedge clk); #1; g++; end
        a_out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 256'(a_in_ready), 256'(0));
        end
        @(posedge clk); #1;
        a_out_ready = 1;
      end
    join
    drain_a();
    count_a("bp", 6, 1);

    // random stalls on both sides
    rnd_ready = 1;
    send_a(8'h20, 0, AW*AH, 1);
    send_a(8'h40, 0, AW*AH, 1);
    rnd_ready = 0;
    @(posedge clk); #2;
    a_out_ready = 1;
    drain_a();
    count_a("rand", 12, 2);
    chk("rand_pos_wrap", 256'({a_row, a_col}), 256'(0));

    // back-to-back frames
    send_a(0, 0, AW*AH, 0);
    send_a(8'h80, 0, AW*AH, 0);
    drain_a();
    count_a("b2b", 12, 2);

    // clear when pixel (2,1) is next
    send_a(0, 0, 2*AW + 1, 0);
    a_clear = 1; a_in_valid = 1; a_data_in = 8'h21;
    @(posedge clk); #1;
    a_clear = 0; a_in_valid = 0;
    @(negedge clk);
    chk("clear_state", 256'({a_win_valid, a_col, a_row}), 256'(0));
    @(posedge clk); #1;
    a_wins = 0; a_lasts = 0;
    send_a(8'h60, 0, AW*AH, 0);
    drain_a();
    count_a("clear", 6, 1);

    // async reset while a window is stalled
    a_out_ready = 0;
    send_a(0, 0, 2*AW + 3, 0);
    @(negedge clk);
    chk("pre_rst_valid", 256'(a_win_valid), 256'(1));
    #2;
    rst_n_a = 0;
    #1;
    chk("async_rst", 256'({a_win_valid, a_win_last, a_col, a_row, a_win_data}), 256'(0));
    @(negedge clk); #2;
    rst_n_a = 1;
    @(posedge clk); #1;
    a_out_ready = 1;
    a_wins = 0; a_lasts = 0;
    send_a(8'h30, 0, AW*AH, 0);
    drain_a();
    count_a("rst", 6, 1);

    // 5x5 kernel on a 7x6 frame
    for (int i = 0; i < BW*BH; i++) begin
      b_in_valid = 1;
      b_data_in  = 8'((i / BW) * 16 + (i % BW));
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    begin
      int g;
      g = 0;
      while ((qb.size() != 0 || b_win_valid) && g < 100) begin @(posedge clk); #1; g++; end
    end
    chk("b_wins", 256'(b_wins), 256'(6));
    chk("b_lasts", 256'(b_lasts), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
